// File: rtl/filter_scheduler_if.sv
// Event port bundle carrying filtered-level change reports to the consumer.
// Latency: n/a (wires only; the producer registers every field it drives).
// Backpressure: evt_ready from the consumer stalls the producer with fields held stable.
interface filter_scheduler_if #(
    parameter int IDX_W = 3
);
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_ch;
    logic             evt_level;

    // Producer side: the scheduler presents events
    modport master (
        output evt_valid,
        output evt_ch,
        output evt_level,
        input  evt_ready
    );

    // Consumer side: the control logic accepts events
    modport slave (
        input  evt_valid,
        input  evt_ch,
        input  evt_level,
        output evt_ready
    );
endinterface

// File: rtl/filter_scheduler.sv
// Shared 4-sample majority debounce for N_CH lines with round-robin change reporting.
// Latency: a held level appears on sig_out at the 5th slot tick of its channel; events follow 1 cycle later.
// Backpressure: evt_ready low holds the presented event; further changes queue as pending bits, repeats flag overrun.
module filter_scheduler #(
    parameter int N_CH  = 8,
    parameter int IDX_W = 3,
    parameter int DIV   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [N_CH-1:0]     sig_in,
    output logic [N_CH-1:0]     sig_out,
    output logic                overrun,
    filter_scheduler_if.master  evt
);

    // Prescaler width; a 1-bit counter is kept even when DIV is 1 so the logic stays uniform.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PCNT_LAST = PW'(DIV - 1);
    localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(N_CH - 1);

    // Event FSM encoding
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    logic [PW-1:0]    pcnt;
    logic [IDX_W-1:0] ptr;
    logic             tick;

    logic [3:0]       hist [N_CH];
    logic [3:0]       cur_hist;
    logic             win_hi;
    logic             win_lo;
    logic             cur_out;
    logic             nxt_out;
    logic             chg;

    logic [N_CH-1:0]  pending;
    logic [N_CH-1:0]  pend_nxt;
    logic             ovr_hit;

    logic [0:0]       state;
    logic             evt_valid_q;
    logic [IDX_W-1:0] evt_ch_q;
    logic             evt_level_q;
    logic [IDX_W-1:0] last;
    logic             acc;

    logic             pick_vld;
    logic [IDX_W-1:0] pick_ch;

    // One filter slot per DIV enabled cycles; the slot is spent on channel ptr.
    assign tick = enable && (pcnt == PCNT_LAST);

    // Prescaler and channel pointer; both freeze while sampling is disabled
    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt <= '0;
            ptr  <= '0;
        end else if (enable) begin
            if (pcnt == PCNT_LAST) begin
                pcnt <= '0;
                ptr  <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    // Shared decision path. The three older history bits vote; the newest
    // stored sample is excluded so a level must survive four slots to win.
    assign cur_hist = hist[ptr];
    assign win_hi   = &cur_hist[3:1];
    assign win_lo   = ~|cur_hist[3:1];
    assign cur_out  = sig_out[ptr];

    // Next filtered level of the channel under service
    always_comb begin
        nxt_out = cur_out;
        if (win_hi) begin
            nxt_out = 1'b1;
        end else if (win_lo) begin
            nxt_out = 1'b0;
        end
    end

    assign chg = tick && (nxt_out != cur_out);

    // Per-channel history shift and filtered output update on the serviced channel
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                hist[c] <= '0;
            end
            sig_out <= '0;
        end else if (tick) begin
            hist[ptr]    <= {cur_hist[2:0], sig_in[ptr]};
            sig_out[ptr] <= nxt_out;
        end
    end

    // Handshake completes when the presented event is taken
    assign acc = evt_valid_q && evt.evt_ready;

    // Pending bits: acceptance clears, a fresh change sets, and the set wins a tie
    always_comb begin
        pend_nxt = pending;
        if (acc) begin
            pend_nxt[evt_ch_q] = 1'b0;
        end
        if (chg) begin
            pend_nxt[ptr] = 1'b1;
        end
    end

    // A change that lands on a still-unreported channel loses information,
    // unless that channel is being accepted in the very same cycle.
    assign ovr_hit = chg && pending[ptr] && !(acc && (evt_ch_q == ptr));

    // Pending vector and sticky overrun flag
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            pending <= pend_nxt;
            if (ovr_hit) begin
                overrun <= 1'b1;
            end
        end
    end

    // Round-robin search over pending channels, starting just after the last grant
    always_comb begin
        logic [IDX_W-1:0] cand;
        int               idx;
        pick_vld = 1'b0;
        pick_ch  = '0;
        cand     = '0;
        idx      = 0;
        for (int i = 1; i <= N_CH; i++) begin
            idx  = (int'(last) + i) % N_CH;
            cand = IDX_W'(idx);
            if (!pick_vld && pending[cand]) begin
                pick_vld = 1'b1;
                pick_ch  = cand;
            end
        end
    end

    // Event FSM: latch one pending channel, hold it until accepted, then release
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_level_q <= 1'b0;
            last        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state       <= ST_PRESENT;
                        evt_valid_q <= 1'b1;
                        evt_ch_q    <= pick_ch;
                        evt_level_q <= sig_out[pick_ch];
                    end
                end
                ST_PRESENT: begin
                    if (acc) begin
                        state       <= ST_IDLE;
                        evt_valid_q <= 1'b0;
                        last        <= evt_ch_q;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    evt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_ch    = evt_ch_q;
    assign evt.evt_level = evt_level_q;

endmodule

// File: tb/tb_filter_scheduler.sv
// Scoreboard bench for filter_scheduler against a sample-list reference model.
// Latency: model advances once per clock edge, checked 1 time unit after the edge.
// Backpressure: evt_ready is driven by directed phases and randomly in the soak phase.
module tb_filter_scheduler;
    localparam int N_CH  = 8;
    localparam int IDX_W = 3;
    localparam int DIV   = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            enable;
    logic [N_CH-1:0] sig_in;
    logic [N_CH-1:0] sig_out;
    logic            overrun;

    filter_scheduler_if #(.IDX_W(IDX_W)) evt ();

    filter_scheduler #(.N_CH(N_CH), .IDX_W(IDX_W), .DIV(DIV)) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .sig_in  (sig_in),
        .sig_out (sig_out),
        .overrun (overrun),
        .evt     (evt)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel keeps its last four samples, oldest first. The decision
    // looks at the three oldest: unanimous ones or zeros set the level.
    bit              smp [N_CH][$];
    bit [N_CH-1:0]   m_out;
    bit [N_CH-1:0]   m_pend;
    bit              m_ovr;
    bit              m_valid;
    int              m_ch;
    bit              m_lvl;
    int              m_last;
    int              en_cnt;
    int              exp_q [$];   // expected events, encoded ch*2+level

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            smp[c].delete();
            for (int k = 0; k < 4; k++) smp[c].push_back(1'b0);
        end
        m_out   = '0;
        m_pend  = '0;
        m_ovr   = 1'b0;
        m_valid = 1'b0;
        m_ch    = 0;
        m_lvl   = 1'b0;
        m_last  = 0;
        en_cnt  = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit            acc;
        bit            do_tick;
        bit            new_o;
        bit            chg;
        int            tc;
        int            ones;
        int            c;
        bit [N_CH-1:0] pend_old;
        bit [N_CH-1:0] out_old;
        if (reset) begin
            model_reset();
        end else begin
            acc      = m_valid && evt.evt_ready;
            pend_old = m_pend;
            out_old  = m_out;
            do_tick  = 1'b0;
            chg      = 1'b0;
            tc       = 0;
            if (enable) begin
                en_cnt++;
                if (en_cnt % DIV == 0) begin
                    do_tick = 1'b1;
                    tc = (en_cnt / DIV - 1) % N_CH;
                end
            end
            if (do_tick) begin
                ones  = int'(smp[tc][0]) + int'(smp[tc][1]) + int'(smp[tc][2]);
                new_o = out_old[tc];
                if (ones == 3) new_o = 1'b1;
                else if (ones == 0) new_o = 1'b0;
                chg = (new_o != out_old[tc]);
                m_out[tc] = new_o;
                smp[tc].push_back(sig_in[tc]);
                void'(smp[tc].pop_front());
            end
            if (acc) m_pend[m_ch] = 1'b0;
            if (chg) begin
                if (pend_old[tc] && !(acc && m_ch == tc)) m_ovr = 1'b1;
                m_pend[tc] = 1'b1;
            end
            if (m_valid) begin
                if (acc) begin
                    m_valid = 1'b0;
                    m_last  = m_ch;
                end
            end else begin
                for (int i = 1; i <= N_CH; i++) begin
                    c = (m_last + i) % N_CH;
                    if (pend_old[c]) begin
                        m_valid = 1'b1;
                        m_ch    = c;
                        m_lvl   = out_old[c];
                        exp_q.push_back(c * 2 + int'(m_lvl));
                        break;
                    end
                end
            end
        end
    endtask

    // Would the coming edge flip channel ch's filtered level?
    function automatic bit will_change(input int ch);
        int n;
        int ones;
        n = en_cnt + 1;
        if (!enable || reset) return 1'b0;
        if (n % DIV != 0) return 1'b0;
        if ((n / DIV - 1) % N_CH != ch) return 1'b0;
        ones = int'(smp[ch][0]) + int'(smp[ch][1]) + int'(smp[ch][2]);
        return (ones == 3 && !m_out[ch]) || (ones == 0 && m_out[ch]);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int  cyc = -1;
    int  rise_cyc = -1;
    int  pres_cyc = -1;
    int  first_acc_cyc = -1;
    int  pres_total = 0;
    int  pres_cnt [N_CH];
    int  acc_cnt  [N_CH];
    int  acc_q [$];
    bit  p_valid = 1'b0;
    int  p_ch = 0;
    bit  p_lvl = 1'b0;

    initial begin
        bit hs;
        int e;
        forever begin
            @(posedge clock);
            #1;
            hs = !reset && p_valid && evt.evt_ready;
            model_step();
            if (reset) begin
                cyc = -1; rise_cyc = -1; pres_cyc = -1; first_acc_cyc = -1;
                pres_total = 0;
                acc_q.delete();
                for (int c = 0; c < N_CH; c++) begin
                    pres_cnt[c] = 0;
                    acc_cnt[c]  = 0;
                end
            end else begin
                cyc++;
            end
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_evt", p_ch * 2 + int'(p_lvl), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_evt_ch2_plus_level", p_ch * 2 + int'(p_lvl), e);
                end
                acc_q.push_back(p_ch * 2 + int'(p_lvl));
                acc_cnt[p_ch]++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
            chk("sig_out", int'(sig_out), int'(m_out));
            chk("overrun", int'(overrun), int'(m_ovr));
            chk("evt_valid", int'(evt.evt_valid), int'(m_valid));
            if (p_valid && !hs && !reset) begin
                chk("evt_ch_stable", int'(evt.evt_ch), p_ch);
                chk("evt_level_stable", int'(evt.evt_level), int'(p_lvl));
            end
            if (!reset && evt.evt_valid && !p_valid) begin
                pres_cnt[int'(evt.evt_ch)]++;
                pres_total++;
                if (pres_cyc < 0) pres_cyc = cyc;
            end
            if (!reset && sig_out[0] && rise_cyc < 0) rise_cyc = cyc;
            p_valid = evt.evt_valid;
            p_ch    = int'(evt.evt_ch);
            p_lvl   = evt.evt_level;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
    endtask

    // ch < 0 waits for any event
    task automatic wait_evt(input int ch, input int budget, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (evt.evt_valid && (ch < 0 || int'(evt.evt_ch) == ch)) found = 1'b1;
            else step(1);
        end
        chk(name, int'(found), 1);
    endtask

    // Raise evt_ready for exactly the cycle in which ch's level flips
    task automatic accept_on_change(input int ch, input int budget, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (will_change(ch)) begin
                evt.evt_ready = 1'b1;
                step(1);
                evt.evt_ready = 1'b0;
                found = 1'b1;
            end else begin
                step(1);
            end
        end
        chk(name, int'(found), 1);
    endtask

    initial begin
        logic [N_CH-1:0] saved;
        int              exp_rr [4];
        reset = 1'b1;
        enable = 1'b1;
        sig_in = '1;
        evt.evt_ready = 1'b0;
        step(3);

        // Debounce latency on channel 0
        reset = 1'b0;
        sig_in = 8'h01;
        evt.evt_ready = 1'b1;
        step(140);
        chk("deb_rise_cyc", rise_cyc, 131);
        chk("deb_present_cyc", pres_cyc, 132);
        chk("deb_accept_cyc", first_acc_cyc, 133);
        chk("deb_first_evt", (acc_q.size() > 0) ? acc_q[0] : -1, 1);

        // Two-slot glitch on channel 2 is rejected
        sig_in[2] = 1'b1;
        step(2 * N_CH * DIV);
        sig_in[2] = 1'b0;
        step(200);
        chk("glitch_sig_out2", int'(sig_out[2]), 0);
        chk("glitch_no_evt", pres_cnt[2], 0);

        // Round-robin with last=3: ch3 held, then re-set in its acceptance cycle
        do_reset();
        sig_in = '0;
        sig_in[3] = 1'b1;
        wait_evt(3, 400, "rr_wait_ch3");
        sig_in[6] = 1'b1;
        sig_in[1] = 1'b1;
        step(N_CH * DIV);
        sig_in[3] = 1'b0;
        accept_on_change(3, 400, "rr_timed_accept");
        chk("rr_overrun", int'(overrun), 0);
        evt.evt_ready = 1'b1;
        step(80);
        exp_rr = '{3 * 2 + 1, 6 * 2 + 1, 1 * 2 + 1, 3 * 2 + 0};
        chk("rr_acc_count", acc_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", (acc_q.size() > i) ? acc_q[i] : -1, exp_rr[i]);
        end

        // Overrun: channel 5 toggles twice while blocked
        do_reset();
        evt.evt_ready = 1'b0;
        sig_in = '0;
        sig_in[5] = 1'b1;
        step(200);
        sig_in[5] = 1'b0;
        step(200);
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_one_present", pres_cnt[5], 1);
        evt.evt_ready = 1'b1;
        step(40);
        chk("ovr_one_accept", acc_cnt[5], 1);

        // Same-cycle set/clear on channel 4
        do_reset();
        evt.evt_ready = 1'b0;
        sig_in = '0;
        sig_in[4] = 1'b1;
        wait_evt(4, 400, "ss_wait_ch4");
        sig_in[4] = 1'b0;
        accept_on_change(4, 400, "ss_timed_accept");
        chk("ss_overrun", int'(overrun), 0);
        evt.evt_ready = 1'b1;
        step(60);
        chk("ss_ch4_accepts", acc_cnt[4], 2);
        chk("ss_ch4_new_level", (acc_q.size() > 0) ? acc_q[acc_q.size() - 1] : -1, 4 * 2 + 0);

        // enable low freezes sampling while the handshake completes
        do_reset();
        evt.evt_ready = 1'b0;
        sig_in = '0;
        sig_in[7] = 1'b1;
        wait_evt(7, 400, "en_wait_ch7");
        enable = 1'b0;
        saved = sig_out;
        sig_in = 8'h5A;
        step(5);
        evt.evt_ready = 1'b1;
        step(15);
        chk("en_sig_out_frozen", int'(sig_out), int'(saved));
        chk("en_evt_completed", acc_cnt[7], 1);
        enable = 1'b1;
        step(300);

        // Reset while an event is presented
        evt.evt_ready = 1'b0;
        sig_in = ~sig_out;
        wait_evt(-1, 400, "mr_wait_any");
        reset = 1'b1;
        step(1);
        chk("mr_valid_low", int'(evt.evt_valid), 0);
        reset = 1'b0;
        sig_in = '0;
        step(150);
        chk("mr_no_represent", pres_total, 0);

        // Randomized soak
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) sig_in[$urandom_range(0, N_CH - 1)] ^= 1'b1;
            evt.evt_ready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 29) != 0);
            reset = ($urandom_range(0, 999) == 0);
            step(1);
        end

        // Drain
        reset = 1'b0;
        enable = 1'b1;
        evt.evt_ready = 1'b1;
        step(600);
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_valid_low", int'(evt.evt_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/filter_scheduler.md
# filter_scheduler

Time-multiplexed debounce controller that shares one 4-sample majority filter decision path among `N_CH` asynchronous-free (already synchronised) input lines. A prescaler and round-robin channel pointer sequence the filter, one channel per sample slot. Per-channel history and output state are kept locally. Filtered-level changes are reported to a downstream consumer through a valid/ready event port with a round-robin pending arbiter. The block sits between the board-level input bank and the control FSMs that previously each instantiated a private filter.

## Interface
- `N_CH`, 8: number of input channels, 2..16.
- `IDX_W`, 3: channel index width, equal to clog2(`N_CH`).
- `DIV`, 4: clock cycles per channel slot, at least 1.

- `clock` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: when low, sampling is frozen; the event port keeps running.
- `sig_in` in `N_CH`: raw input lines, one bit per channel.
- `sig_out` out `N_CH`: filtered levels, registered.
- `evt_valid` out 1: event present on `evt_ch`/`evt_level`.
- `evt_ready` in 1: consumer accepts the event when high together with `evt_valid`.
- `evt_ch` out `IDX_W`: channel whose filtered level changed.
- `evt_level` out 1: value of `sig_out[evt_ch]` latched when the event was presented.
- `overrun` out 1: sticky; a channel changed again while its previous change was still unreported.

## Operation
- **Prescaler** `pcnt` counts 0..`DIV`-1 while `enable`=1.
- **Slot tick** fires when `pcnt`=`DIV`-1 and `enable`=1. At a slot tick, `pcnt` returns to 0 and channel pointer `ptr` advances by one, wrapping from `N_CH`-1 to 0.
- **Per-channel history** `hist[c]` is 4 bits; `hist[c][0]` holds the newest sample.
- **Filter step** runs only at a slot tick, on channel c = `ptr`:
  - Compute `j` = AND of `hist[c][3:1]` and `k` = NOR of `hist[c][3:1]`, both from pre-update values.
  - Shift: `hist[c]` <= {`hist[c][2:0]`, `sig_in[c]`}.
  - `sig_out[c]` <= 1 if j, 0 if k, otherwise unchanged. j and k are never both true.
- **Change detect:** if the filter step changes `sig_out[c]`, set `pending[c]`.
  - If `pending[c]` was already 1 and is not being cleared in the same cycle, set `overrun` as well.
- **Event FSM:**
  - IDLE: if any `pending` bit is set, select one by round-robin, starting at `last`+1 (`last` is the previously granted channel, reset 0). Latch `evt_ch` and `evt_level` = current `sig_out[ch]`, assert `evt_valid`, and go to PRESENT.
  - PRESENT: hold `evt_valid`, `evt_ch` and `evt_level` stable until `evt_valid`=1 and `evt_ready`=1. In that cycle, clear `pending[evt_ch]`, set `last` = `evt_ch`, drop `evt_valid`, and go to IDLE.
  - If a change on `evt_ch` sets `pending` in the same cycle as its acceptance, the set wins. The channel is re-presented later with its then-current level, and `overrun` is not set.
- **enable = 0:** `pcnt`, `ptr`, `hist` and `sig_out` hold. The event FSM and handshake continue normally.
- **Reset (any cycle, including mid-handshake):** the following all return to 0 on the next edge: `pcnt`, `ptr`, `last`, every `hist`, `sig_out`, `pending`, `overrun`, `evt_valid`, `evt_ch` and `evt_level`. The FSM returns to IDLE. An event being presented is discarded.

## Timing
- Cycle 0 is the first rising edge with `reset`=0 and `enable`=1.
- Channel c is sampled at cycles c·`DIV`+`DIV`-1 + m·`N_CH`·`DIV`, for m = 0, 1, 2, ...
- A level held constant is reflected in `sig_out[c]` on the 5th slot tick of channel c after the level is first sampled. The `sig_out` change is visible after that edge.
- `evt_valid` rises at the earliest 1 cycle after the `pending` bit is set, and at the earliest 1 cycle after the previous acceptance. This gives a minimum 1-cycle bubble between events.
- All outputs are registered. No combinational path exists from `evt_ready` or `sig_in` to any output.

## Test plan
- **Reset values:** hold `reset` for 3 cycles with `sig_in`=8'hFF, then release. Required: all outputs 0 during and immediately after reset.
- **Debounce latency:** `N_CH`=8, `DIV`=4, `sig_in[0]`=1 held from cycle 0, `evt_ready`=1. Required: `sig_out[0]` rises after the cycle-131 edge. `evt_valid`=1 with `evt_ch`=0 and `evt_level`=1 in the following cycle, accepted in that same cycle.
- **Glitch rejection:** on channel 2 (steady low), pulse the input high for exactly 2 consecutive slot ticks. Required: `sig_out[2]` stays 0 and no event is raised.
- **Round-robin arbitration:** channels 1, 3 and 6 all change on the same rotation while `evt_ready`=0, with `last`=3. Then raise `evt_ready`. Required: events are presented in order 6, 1, 3, each with stable fields until accepted.
- **Overrun and same-cycle set/clear:**
  - Toggle channel 5 twice with `evt_ready`=0. Required: `overrun`=1 and only one event is presented.
  - Separately, accept channel 4's event in the same cycle channel 4 changes. Required: `overrun` stays 0 and channel 4 is re-presented with its new level.
- **enable and mid-handshake reset:** drive `enable` low for 20 cycles. Required: `ptr`, `pcnt` and `sig_out` are frozen while a pending event still completes. Then assert `reset` while `evt_valid`=1. Required: `evt_valid`=0 on the next cycle and nothing is re-presented.
